or3_rr_arbiter: RTL and testbench
=================================

# or3_rr_arbiter

Three-requester round-robin arbiter that shares a single resource among three clients. It watches three request lines and issues a registered one-hot grant to exactly one requester at a time. Each grant is held until the owner releases its request or a hold-time limit expires. It sits in front of any 3:1 shared datapath in the logic-design series, and `busy` is the OR of the grant lines for downstream enables.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive grant cycles while another requester is waiting; range 1..255; 0 disables the limit.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rstn` input 1: asynchronous active-low reset.
- `req` input 3: request lines; `req[i]`=1 means client i wants the resource.
- `gnt` output 3: registered one-hot grant; all zero when no grant is active.
- `gnt_id` output 2: index of the current owner, 0..2; value 3 when no grant is active.
- `busy` output 1: registered; equals `gnt[0] | gnt[1] | gnt[2]`.

## Operation
- State: FSM with states IDLE and GRANT; 2-bit priority pointer `ptr` (0..2); 2-bit `owner`; 8-bit hold counter `hcnt`.
- Reset (`rstn`=0, asynchronous):
  - state=IDLE, `ptr`=0, `hcnt`=0.
  - `gnt`=3'b000, `gnt_id`=3, `busy`=0.
- IDLE:
  - If `req`==0, stay in IDLE.
  - Otherwise pick the first i with `req[i]`=1, searching `ptr`, `ptr`+1, `ptr`+2 (mod 3).
  - Set `owner`=i, `gnt`=one-hot(i), `gnt_id`=i, `busy`=1, `hcnt`=1, go to GRANT.
- GRANT, evaluated in order:
  1. Release: `req[owner]`=0 → `gnt`=0, `gnt_id`=3, `busy`=0, `ptr`=(`owner`+1) mod 3, go to IDLE.
  2. Forced release: `HOLD_MAX`≠0, `hcnt`≥`HOLD_MAX`, and any other `req` bit is 1 → same actions as release.
  3. Otherwise hold the grant. `hcnt` increments and saturates at 255.
- The hold limit applies only while someone else is waiting. A lone requester keeps the grant indefinitely.
- After any release, the former owner has lowest priority in the next arbitration.
- `ptr` changes only on release. It is never changed by arbitration alone.
- `gnt` is never multi-hot. `gnt_id` and `busy` are always consistent with `gnt`.
- Mod-3 arithmetic: `ptr`=2 wraps to 0. Value 3 is never stored in `ptr` or `owner`.

## Timing
- Grant latency: `req` sampled high at edge N (from IDLE) → `gnt` high after edge N, i.e. one cycle.
- Release latency: `req[owner]` sampled low at edge N → `gnt` low after edge N.
- Mandatory turnaround: at least one full cycle with `gnt`=0 between any two grants. The earliest next grant comes after edge N+1.
- Forced release timing: `gnt` is high for exactly `HOLD_MAX` cycles, then drops on the following edge.
- Simultaneous requests arriving in IDLE: resolved by `ptr` only. Request arrival order is ignored.
- A request pulse shorter than one cycle that is not sampled on an edge is ignored.
- Reset asserted mid-grant: `gnt`, `gnt_id` and `busy` clear immediately (asynchronously). After deassertion, arbitration restarts from `ptr`=0.
- `req` is assumed synchronous to `clk`. Synchronizing external pins is the caller's job.

## Test plan
- **Reset:** hold `rstn`=0 with `req`=3'b111.
  - Required: `gnt`=000, `gnt_id`=3, `busy`=0.
  - Release reset: `gnt`=001 one cycle later.
- **Single requester:** `req`=010 for 5 cycles, then 000.
  - Required: `gnt`=010 from cycle 1 through cycle 5, `gnt_id`=1, `busy`=1.
  - `gnt`=000 one cycle after the drop.
- **Round robin:** `req`=111 constant, `HOLD_MAX`=0, each owner drops its request for one cycle after 2 cycles of grant.
  - Required: grant order 0,1,2,0.
  - Exactly one zero-grant cycle between consecutive grants.
- **Hold limit:** `HOLD_MAX`=4, `req`=101 constant.
  - Required: `gnt`=001 for 4 cycles, then 000 for 1 cycle, then 100 for 4 cycles, then 001.
  - With `req`=001 only: `gnt`=001 held for more than 20 cycles.
- **Wrap-around:** client 2 releases while `req`=011.
  - Required: `ptr`=0 and the next grant goes to client 0.
- **Reset mid-operation:** pulse `rstn` low for 0.5 cycles during a grant to client 2.
  - Required: `gnt` clears before the next edge.
  - With `req`=110 afterwards, the next grant goes to client 1.

Source files
------------

// File: rtl/or3_rr_arbiter.sv
// rtl/or3_rr_arbiter.sv - three-requester round-robin arbiter with hold-time limit
module or3_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] req,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0] LP_HOLD    = 8'(HOLD_MAX);
  localparam logic       LP_HOLD_EN = (HOLD_MAX != 0);

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_owner;
  logic [7:0] r_hcnt;
  logic [2:0] r_gnt;
  logic [1:0] r_gnt_id;
  logic       r_busy;

  logic [1:0] w_pick;
  logic [1:0] w_next_ptr;
  logic       w_owner_req;
  logic       w_others;
  logic       w_hold_hit;
  logic       w_release;

  // First requester at or after ptr, mod 3; only meaningful when req != 0
  always_comb begin
    w_pick = 2'd0;
    case (r_ptr)
      2'd0:    w_pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
      2'd1:    w_pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
      2'd2:    w_pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
      default: w_pick = 2'd0;
    endcase
  end

  // Release decision: r_gnt is one-hot of the owner while in GRANT
  always_comb begin
    w_owner_req = |(req & r_gnt);
    w_others    = |(req & ~r_gnt);
    w_hold_hit  = LP_HOLD_EN && (r_hcnt >= LP_HOLD);
    w_release   = !w_owner_req || (w_hold_hit && w_others);
    w_next_ptr  = (r_owner == 2'd2) ? 2'd0 : (r_owner + 2'd1);
  end

  // Arbitration FSM with registered grant outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_ptr    <= 2'd0;
      r_owner  <= 2'd0;
      r_hcnt   <= 8'd0;
      r_gnt    <= 3'b000;
      r_gnt_id <= 2'd3;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req != 3'b000) begin
            r_owner  <= w_pick;
            r_gnt    <= 3'b001 << w_pick;
            r_gnt_id <= w_pick;
            r_busy   <= 1'b1;
            r_hcnt   <= 8'd1;
            r_state  <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_release) begin
            r_gnt    <= 3'b000;
            r_gnt_id <= 2'd3;
            r_busy   <= 1'b0;
            r_ptr    <= w_next_ptr;
            r_state  <= ST_IDLE;
          end else if (r_hcnt != 8'hFF) begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign gnt    = r_gnt;
  assign gnt_id = r_gnt_id;
  assign busy   = r_busy;

endmodule

// File: tb/tb_or3_rr_arbiter.sv
// tb/tb_or3_rr_arbiter.sv - self-checking bench for or3_rr_arbiter (HOLD_MAX 0, 4, 8)
module tb_or3_rr_arbiter;

  logic       clk;
  logic       rstn;
  logic [2:0] req;
  logic [2:0] gnt_w  [3];
  logic [1:0] id_w   [3];
  logic       busy_w [3];

  int n_cmp;
  int n_fail;

  // reference model state, one per instance (owner -1 = no grant)
  int m_owner [3];
  int m_ptr   [3];
  int m_hcnt  [3];
  int hold_of [3];

  or3_rr_arbiter #(.HOLD_MAX(0)) u_dut_h0 (
    .clk(clk), .rstn(rstn), .req(req),
    .gnt(gnt_w[0]), .gnt_id(id_w[0]), .busy(busy_w[0]));
  or3_rr_arbiter #(.HOLD_MAX(4)) u_dut_h4 (
    .clk(clk), .rstn(rstn), .req(req),
    .gnt(gnt_w[1]), .gnt_id(id_w[1]), .busy(busy_w[1]));
  or3_rr_arbiter u_dut_h8 (
    .clk(clk), .rstn(rstn), .req(req),
    .gnt(gnt_w[2]), .gnt_id(id_w[2]), .busy(busy_w[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_owner[d] = -1;
      m_ptr[d]   = 0;
      m_hcnt[d]  = 0;
    end
  endtask

  task automatic model_step(input logic [2:0] r);
    int  i;
    bit  others;
    for (int d = 0; d < 3; d++) begin
      if (m_owner[d] < 0) begin
        for (int k = 0; k < 3; k++) begin
          i = (m_ptr[d] + k) % 3;
          if (r[i] && m_owner[d] < 0) begin
            m_owner[d] = i;
            m_hcnt[d]  = 1;
          end
        end
      end else begin
        others = (r & ~(3'b001 << m_owner[d])) != 3'b000;
        if (!r[m_owner[d]] || (hold_of[d] != 0 && m_hcnt[d] >= hold_of[d] && others)) begin
          m_ptr[d]   = (m_owner[d] + 1) % 3;
          m_owner[d] = -1;
        end else if (m_hcnt[d] < 255) begin
          m_hcnt[d] = m_hcnt[d] + 1;
        end
      end
    end
  endtask

  function automatic logic [2:0] exp_gnt(input int d);
    return (m_owner[d] < 0) ? 3'b000 : 3'(3'b001 << m_owner[d]);
  endfunction

  function automatic logic [1:0] exp_id(input int d);
    return (m_owner[d] < 0) ? 2'd3 : 2'(m_owner[d]);
  endfunction

  // drive req, take one rising edge, advance model, sample 1 time unit later
  task automatic tick(input logic [2:0] r);
    req = r;
    @(posedge clk);
    if (rstn) model_step(r);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    req  = 3'b000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req  = 3'b111;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (gnt_w[d] !== 3'b000) begin
        n_fail++; $display("FAIL reset_gnt dut%0d: got %b want 000", d, gnt_w[d]);
      end
      n_cmp++;
      if (id_w[d] !== 2'd3) begin
        n_fail++; $display("FAIL reset_id dut%0d: got %0d want 3", d, id_w[d]);
      end
      n_cmp++;
      if (busy_w[d] !== 1'b0) begin
        n_fail++; $display("FAIL reset_busy dut%0d: got %b want 0", d, busy_w[d]);
      end
    end
    rstn = 1'b1;
    tick(3'b111);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (gnt_w[d] !== 3'b001) begin
        n_fail++; $display("FAIL reset_first_gnt dut%0d: got %b want 001", d, gnt_w[d]);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      tick(3'b010);
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (gnt_w[d] !== 3'b010 || id_w[d] !== 2'd1 || busy_w[d] !== 1'b1) begin
          n_fail++;
          $display("FAIL single_hold dut%0d cyc%0d: got gnt=%b id=%0d busy=%b want 010/1/1",
                   d, c, gnt_w[d], id_w[d], busy_w[d]);
        end
      end
    end
    tick(3'b000);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (gnt_w[d] !== 3'b000 || id_w[d] !== 2'd3 || busy_w[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL single_drop dut%0d: got gnt=%b id=%0d busy=%b want 000/3/0",
                 d, gnt_w[d], id_w[d], busy_w[d]);
      end
    end
  endtask

  task automatic test_round_robin();
    int         order [4];
    logic [2:0] oh;
    order = '{0, 1, 2, 0};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      oh = 3'(3'b001 << order[k]);
      for (int c = 0; c < 2; c++) begin
        tick(3'b111);
        n_cmp++;
        if (gnt_w[0] !== oh) begin
          n_fail++; $display("FAIL rr_grant step%0d: got %b want %b", k, gnt_w[0], oh);
        end
      end
      tick(3'b111 & ~oh);
      n_cmp++;
      if (gnt_w[0] !== 3'b000) begin
        n_fail++; $display("FAIL rr_gap step%0d: got %b want 000", k, gnt_w[0]);
      end
    end
  endtask

  task automatic test_hold_limit();
    logic [2:0] seq [11];
    seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
            3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b001};
    do_reset();
    for (int c = 0; c < 11; c++) begin
      tick(3'b101);
      n_cmp++;
      if (gnt_w[1] !== seq[c]) begin
        n_fail++; $display("FAIL hold4_seq cyc%0d: got %b want %b", c, gnt_w[1], seq[c]);
      end
      n_cmp++;
      if (gnt_w[0] !== 3'b001) begin
        n_fail++; $display("FAIL hold0_keep cyc%0d: got %b want 001", c, gnt_w[0]);
      end
    end
    do_reset();
    for (int c = 0; c < 25; c++) begin
      tick(3'b001);
      n_cmp++;
      if (gnt_w[1] !== 3'b001) begin
        n_fail++; $display("FAIL hold4_lone cyc%0d: got %b want 001", c, gnt_w[1]);
      end
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(3'b100);
    n_cmp++;
    if (gnt_w[2] !== 3'b100) begin
      n_fail++; $display("FAIL wrap_own2: got %b want 100", gnt_w[2]);
    end
    tick(3'b011);
    n_cmp++;
    if (gnt_w[2] !== 3'b000) begin
      n_fail++; $display("FAIL wrap_gap: got %b want 000", gnt_w[2]);
    end
    tick(3'b011);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (gnt_w[d] !== 3'b001 || id_w[d] !== 2'd0) begin
        n_fail++; $display("FAIL wrap_next dut%0d: got gnt=%b id=%0d want 001/0", d, gnt_w[d], id_w[d]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(3'b100);
    tick(3'b100);
    n_cmp++;
    if (gnt_w[2] !== 3'b100) begin
      n_fail++; $display("FAIL mid_pre: got %b want 100", gnt_w[2]);
    end
    rstn = 1'b0;
    model_reset();
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (gnt_w[d] !== 3'b000 || id_w[d] !== 2'd3 || busy_w[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_async dut%0d: got gnt=%b id=%0d busy=%b want 000/3/0",
                 d, gnt_w[d], id_w[d], busy_w[d]);
      end
    end
    #4;
    rstn = 1'b1;
    tick(3'b110);
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (gnt_w[d] !== 3'b010) begin
        n_fail++; $display("FAIL mid_after dut%0d: got %b want 010", d, gnt_w[d]);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] r;
    r = 3'b000;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 9) < 3) r = 3'($urandom_range(0, 7));
      tick(r);
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (gnt_w[d] !== exp_gnt(d) || id_w[d] !== exp_id(d) || busy_w[d] !== (m_owner[d] >= 0)) begin
          n_fail++;
          $display("FAIL random dut%0d cyc%0d req=%b: got gnt=%b id=%0d busy=%b want gnt=%b id=%0d",
                   d, c, r, gnt_w[d], id_w[d], busy_w[d], exp_gnt(d), exp_id(d));
        end
      end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    hold_of = '{0, 4, 8};
    rstn    = 1'b0;
    req     = 3'b000;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_hold_limit();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
